// File: rtl/tri_row_stream.sv
// Triangular-matrix row fetch sequencer with a credit-limited, masking row buffer.
// Latency: request 1 cycle after start, row out 1 cycle after return; valid/ready stalls hold the head row.

// Generic FIFO: 1-cycle write-to-read, pointers wrap at any DEPTH, clr_i empties it.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop;

  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(wr_vld) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_vld && !clr_i) mem[wr_ptr] <= wr_dat;
  end
endmodule

module tri_row_stream #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [$clog2(SIZE+1)-1:0] n_i,
  input  logic                      upper_i,
  input  logic                      flush_i,
  output logic [$clog2(SIZE)-1:0]   mat_row_addr_o,
  output logic                      mat_row_addr_valid_o,
  input  logic [SIZE*2*WIDTH-1:0]   mat_row_i,
  input  logic                      mat_row_valid_i,
  input  logic [$clog2(SIZE)-1:0]   mat_row_addr_i,
  output logic [SIZE*2*WIDTH-1:0]   row_o,
  output logic [$clog2(SIZE)-1:0]   row_idx_o,
  output logic                      row_valid_o,
  input  logic                      row_ready_i,
  output logic                      row_last_o,
  output logic                      sing_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);
  localparam int NW = $clog2(SIZE+1);
  localparam int AW = $clog2(SIZE);
  localparam int EW = 2*WIDTH;
  localparam int RW = SIZE*EW;
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = RW + AW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_m1, iss_cnt, ret_cnt, exp_idx;
  logic          upper_q;
  logic [CW-1:0] out_cnt, fifo_cnt;
  logic [CW:0]   used;
  logic          credit_ok, start_ok, ret_take, last_pop;
  logic [AW-1:0] iss_addr;
  logic [RW-1:0] masked_row;
  logic [EW-1:0] diag;
  logic          diag_zero;
  logic [FW-1:0] fifo_wr_dat, fifo_rd_dat;
  logic          fifo_vld;
  logic [RW-1:0] head_row;
  logic [AW-1:0] head_idx;
  logic          head_last, head_sing;

  assign n_m1      = n_q - NW'(1);
  assign used      = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign credit_ok = (used < (CW+1)'(DEPTH));
  assign start_ok  = (state_q == IDLE) && start_i && !flush_i && (n_i != '0) &&
                     (n_i <= NW'(SIZE)) && (out_cnt == '0);
  // Returns outside ISSUE/DRAIN belong to an aborted pass and are dropped.
  assign ret_take  = mat_row_valid_i && !flush_i && (state_q == ISSUE || state_q == DRAIN);
  assign iss_addr  = AW'(upper_q ? (n_m1 - iss_cnt) : iss_cnt);
  assign exp_idx   = upper_q ? (n_m1 - ret_cnt) : ret_cnt;
  assign last_pop  = row_valid_o && row_ready_i && row_last_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = ISSUE;
        ISSUE:   if (mat_row_addr_valid_o && (iss_cnt == n_m1)) state_d = DRAIN;
        DRAIN:   if (last_pop) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mat_row_addr_valid_o = 1'b0;
    mat_row_addr_o       = '0;
    busy_o               = 1'b0;
    done_o               = 1'b0;
    case (state_q)
      ISSUE: begin
        busy_o = 1'b1;
        if (credit_ok) begin
          mat_row_addr_valid_o = 1'b1;
          mat_row_addr_o       = iss_addr;
        end
      end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q     <= '0;
      upper_q <= 1'b0;
      iss_cnt <= '0;
      ret_cnt <= '0;
      err_o   <= 1'b0;
    end else if (start_ok) begin
      n_q     <= n_i;
      upper_q <= upper_i;
      iss_cnt <= '0;
      ret_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      if (mat_row_addr_valid_o) iss_cnt <= iss_cnt + NW'(1);
      if (ret_take) begin
        ret_cnt <= ret_cnt + NW'(1);
        if (mat_row_addr_i != exp_idx[AW-1:0]) err_o <= 1'b1;
      end
    end
  end

  // Outstanding requests survive a flush so a restart waits for stale returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt <= '0;
    end else begin
      case ({mat_row_addr_valid_o, mat_row_valid_i})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    masked_row = mat_row_i;
    diag       = '0;
    for (int j = 0; j < SIZE; j++) begin
      if ((upper_q ? (NW'(j) < exp_idx) : (NW'(j) > exp_idx)) || (NW'(j) >= n_q))
        masked_row[j*EW +: EW] = '0;
      if (NW'(j) == exp_idx) diag = mat_row_i[j*EW +: EW];
    end
  end

  // Sign bits are ignored so that -0.0 counts as a zero diagonal.
  assign diag_zero   = (diag[WIDTH-2:0] == '0) && (diag[EW-2:WIDTH] == '0);
  assign fifo_wr_dat = {(ret_cnt == n_m1), diag_zero, exp_idx[AW-1:0], masked_row};

  sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_row_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .wr_vld (ret_take),
    .wr_dat (fifo_wr_dat),
    .rd_rdy (row_ready_i),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_rd_dat),
    .cnt    (fifo_cnt)
  );

  assign {head_last, head_sing, head_idx, head_row} = fifo_rd_dat;
  assign row_valid_o = fifo_vld;
  assign row_o       = fifo_vld ? head_row  : '0;
  assign row_idx_o   = fifo_vld ? head_idx  : '0;
  assign row_last_o  = fifo_vld && head_last;
  assign sing_o      = fifo_vld && head_sing;
endmodule

// File: tb/tb_tri_row_stream.sv
// Randomized bench for tri_row_stream: behavioural memory with fixed latency,
// expected row stream built directly from the triangle/mask/singularity rules.
module tb_tri_row_stream;
  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int NW    = $clog2(SIZE+1);
  localparam int AW    = $clog2(SIZE);
  localparam int EW    = 2*WIDTH;
  localparam int RW    = SIZE*EW;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [NW-1:0] n_i = '0;
  logic          upper_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [AW-1:0] mat_row_addr_o;
  logic          mat_row_addr_valid_o;
  logic [RW-1:0] mat_row_i = '0;
  logic          mat_row_valid_i = 1'b0;
  logic [AW-1:0] mat_row_addr_i = '0;
  logic [RW-1:0] row_o;
  logic [AW-1:0] row_idx_o;
  logic          row_valid_o;
  logic          row_ready_i = 1'b0;
  logic          row_last_o, sing_o, busy_o, done_o, err_o;

  tri_row_stream #(.SIZE(SIZE), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .n_i(n_i), .upper_i(upper_i),
    .flush_i(flush_i), .mat_row_addr_o(mat_row_addr_o), .mat_row_addr_valid_o(mat_row_addr_valid_o),
    .mat_row_i(mat_row_i), .mat_row_valid_i(mat_row_valid_i), .mat_row_addr_i(mat_row_addr_i),
    .row_o(row_o), .row_idx_o(row_idx_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .row_last_o(row_last_o), .sing_o(sing_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [RW-1:0] row; int idx; bit last; bit sing; } exp_t;
  typedef struct { int addr; int due; } req_t;

  logic [EW-1:0]   mat [SIZE][SIZE];
  exp_t            exp_q[$];
  int              exp_addr_q[$];
  req_t            pend_q[$];
  int              total, bad, cyc, lat, ready_mode, out_now;
  int              issued, consumed, exp_done_cyc, done_cnt, last_addr_cyc;
  bit              chk_gap, bad_tag_en, stall_prev;
  logic [RW-1:0]   held_row;
  logic [AW+1:0]   held_meta;

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_zero(input logic [WIDTH-1:0] x);
    return x[WIDTH-2:0] == '0;
  endfunction

  function automatic logic [RW-1:0] ref_row(input int i, input int n, input bit up);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < SIZE; j++)
      if (up ? (j >= i && j < n) : (j <= i && j < n)) r[j*EW +: EW] = mat[i][j];
    return r;
  endfunction

  task automatic fill_mat();
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) mat[i][j] = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        mat[i][i] = '0;
        mat[i][i][EW-1]    = 1'($urandom_range(0, 1));
        mat[i][i][WIDTH-1] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) mat[i][i][0] = 1'b1;
      end
    end
  endtask

  // One clock: drive ready and memory return, then observe and score this cycle.
  task automatic tick();
    req_t r;
    exp_t e;
    @(posedge clk_i); #1;
    cyc++;
    out_now = pend_q.size();
    case (ready_mode)
      0:       row_ready_i = 1'b1;
      1:       row_ready_i = (cyc % 2 == 0);
      2:       row_ready_i = ($urandom_range(0, 2) != 0);
      default: row_ready_i = 1'b0;
    endcase
    mat_row_valid_i = 1'b0;
    mat_row_i       = '0;
    mat_row_addr_i  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      mat_row_valid_i = 1'b1;
      for (int j = 0; j < SIZE; j++) mat_row_i[j*EW +: EW] = mat[r.addr][j];
      mat_row_addr_i = (bad_tag_en && r.addr == 2) ? AW'(9) : AW'(r.addr);
    end
    if (mat_row_addr_valid_o) begin
      if (exp_addr_q.size() == 0) chk("addr_extra", mat_row_addr_valid_o, 0);
      else begin
        chk("addr", mat_row_addr_o, exp_addr_q.pop_front());
        if (chk_gap && issued > 0) chk("addr_gap", cyc - last_addr_cyc, 1);
        chk("inflight", (issued + 1 - consumed) <= DEPTH, 1);
      end
      issued++;
      last_addr_cyc = cyc;
      r.addr = int'(mat_row_addr_o);
      r.due  = cyc + lat;
      pend_q.push_back(r);
    end
    if (row_valid_o) begin
      if (stall_prev) begin
        chk("hold_row", row_o == held_row, 1);
        chk("hold_meta", {row_idx_o, row_last_o, sing_o}, held_meta);
      end
      if (row_ready_i) begin
        if (exp_q.size() == 0) chk("row_extra", row_valid_o, 0);
        else begin
          e = exp_q.pop_front();
          chk("idx", row_idx_o, e.idx);
          chk("last", row_last_o, e.last);
          chk("sing", sing_o, e.sing);
          for (int j = 0; j < SIZE; j++)
            chk($sformatf("r%0d_e%0d", e.idx, j), row_o[j*EW +: EW], e.row[j*EW +: EW]);
          consumed++;
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
    end
    stall_prev = row_valid_o && !row_ready_i;
    held_row   = row_o;
    held_meta  = {row_idx_o, row_last_o, sing_o};
    if (done_o || cyc == exp_done_cyc) begin
      chk("done", done_o, cyc == exp_done_cyc);
      chk("busy_at_done", busy_o, 0);
      if (done_o) done_cnt++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic begin_pass(input int n, input bit up, input int l, input int rm, input bit gap);
    exp_t e;
    lat = l; ready_mode = rm; chk_gap = gap;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < n; k++) begin
      e.idx  = up ? n - 1 - k : k;
      e.row  = ref_row(e.idx, n, up);
      e.last = (k == n - 1);
      e.sing = is_zero(mat[e.idx][e.idx][WIDTH-1:0]) && is_zero(mat[e.idx][e.idx][EW-1:WIDTH]);
      exp_q.push_back(e);
      exp_addr_q.push_back(e.idx);
    end
    issued = 0; consumed = 0; done_cnt = 0; exp_done_cyc = -1;
    n_i = NW'(n); upper_i = up; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_req", mat_row_addr_valid_o, 1);
  endtask

  task automatic finish_pass(input bit exp_err);
    int guard = 0;
    while (!(exp_done_cyc >= 0 && cyc >= exp_done_cyc) && guard < 4000) begin
      tick();
      guard++;
    end
    chk("done_once", done_cnt, 1);
    chk("rows_left", exp_q.size(), 0);
    chk("err", err_o, exp_err);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {row_valid_o, mat_row_addr_valid_o, busy_o, done_o, err_o, row_last_o, sing_o}, 0);
    chk({tag, "_idx"}, {row_idx_o, mat_row_addr_o}, 0);
    chk({tag, "_row"}, |row_o, 0);
  endtask

  initial begin
    int guard;
    total = 0; bad = 0; cyc = 0; lat = 1; ready_mode = 0; issued = 0; consumed = 0;
    exp_done_cyc = -1; done_cnt = 0; last_addr_cyc = 0;
    chk_gap = 0; bad_tag_en = 0; stall_prev = 0;
    fill_mat();
    #2;
    check_zero("reset");
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    begin_pass(16, 0, 1, 0, 1); finish_pass(0);
    idle(3);

    fill_mat();
    begin_pass(5, 1, 7, 1, 0); finish_pass(0);
    idle(2);

    fill_mat();
    mat[3][3] = {64'h8000_0000_0000_0000, 64'h0};
    mat[1][1] = {64'h0, $realtobits(1e-300)};
    begin_pass(16, 0, 3, 2, 0); finish_pass(0);
    idle(2);

    // Abort mid-pass; restart must wait for the stale returns to drain.
    fill_mat();
    begin_pass(12, 0, 5, 0, 0);
    guard = 0;
    while (issued < 6 && guard < 200) begin tick(); guard++; end
    flush_i = 1'b1;
    exp_q.delete(); exp_addr_q.delete(); exp_done_cyc = -1;
    tick();
    flush_i = 1'b0;
    chk("flush_valid", row_valid_o, 0);
    chk("flush_busy", busy_o, 0);
    guard = 0;
    while (out_now > 0 && guard < 200) begin
      n_i = NW'(4); upper_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("start_refused", busy_o, 0);
      guard++;
    end
    begin_pass(4, 1, 5, 2, 0); finish_pass(0);
    idle(2);

    fill_mat();
    bad_tag_en = 1;
    begin_pass(8, 0, 2, 2, 0); finish_pass(1);
    bad_tag_en = 0;
    idle(3);
    chk("err_sticky", err_o, 1);
    begin_pass(4, 1, 1, 0, 0);
    chk("err_cleared", err_o, 0);
    finish_pass(0);
    idle(2);

    for (int k = 0; k < 2; k++) begin
      n_i = (k == 0) ? NW'(0) : NW'(17); start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("illegal_start", busy_o, 0);
    end
    n_i = NW'(3); start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_beats_start", busy_o, 0);
    idle(2);

    for (int t = 0; t < 6; t++) begin
      fill_mat();
      begin_pass($urandom_range(1, SIZE), 1'($urandom_range(0, 1)), $urandom_range(1, 8),
                 $urandom_range(0, 2), 0);
      finish_pass(0);
      idle($urandom_range(0, 3));
    end

    // Reset while rows sit stalled in DRAIN.
    fill_mat();
    begin_pass(3, 0, 2, 3, 0);
    idle(8);
    chk("drain_busy", busy_o, 1);
    chk("drain_valid", row_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check_zero("mid_rst");
    exp_q.delete(); exp_addr_q.delete(); pend_q.delete();
    exp_done_cyc = -1; stall_prev = 0; ready_mode = 0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    begin_pass(6, 0, 2, 0, 0); finish_pass(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
